// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- instruction fetch unit
//
// Reads one instruction word per fetch from a synchronous instruction memory
// (data returned the cycle after the read enable), holds it, and offers it
// downstream with a valid/ready handshake. Each instruction takes three cycles:
// FETCH (issue the read), WAIT (latch the returned word), ISSUE (offer it until
// accepted). A redirect from execute discards whatever is in flight and
// refetches from the target. Fetching opcode 4'b1111 parks the unit in HALT
// until reset.
//
// Ports
//   clk           sole clock, rising edge
//   rst_n         synchronous active-low reset
//   imem_en       instruction-memory read enable (high only in FETCH)
//   imem_addr     instruction-memory read address (the PC)
//   imem_data     read data, valid the cycle after imem_en
//   opcode        opcode of the held instruction, NOP (0) while not valid
//   Operands      remaining fields of the held instruction
//   PCOut         address of the held instruction
//   InstrValid    held instruction is offered downstream
//   InstrReady    downstream accepts the offered instruction
//   BranchTaken   redirect request from execute
//   BranchTarget  redirect address
//   Halted        HALT opcode fetched; fetching stopped until reset
//   InstrCount    saturating count of accepted instructions
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [3:0]         opcode,
    output logic [INSTR_W-5:0] Operands,
    output logic [PC_W-1:0]    PCOut,
    output logic               InstrValid,
    input  logic               InstrReady,
    input  logic               BranchTaken,
    input  logic [PC_W-1:0]    BranchTarget,
    output logic               Halted,
    output logic [15:0]        InstrCount
);

    localparam logic [3:0] HALT_OP = 4'b1111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t               state;
    logic [PC_W-1:0]      pc;
    logic [INSTR_W-1:0]   ir;

    wire                  transfer = (state == ISSUE) && InstrReady;
    wire [3:0]            fetched_op = imem_data[INSTR_W-1 -: 4];

    // NOTE: every register in this block is assigned with <= so all updates
    // see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= '0;
            ir         <= '0;
            PCOut      <= '0;
            InstrCount <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (BranchTaken) begin
                        pc    <= BranchTarget;
                        state <= FETCH;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    // A redirect wins over the returned word, including a HALT
                    // opcode: the word is dropped and never reaches ISSUE.
                    if (BranchTaken) begin
                        pc    <= BranchTarget;
                        state <= FETCH;
                    end else begin
                        ir    <= imem_data;
                        PCOut <= pc;
                        state <= (fetched_op == HALT_OP) ? HALT : ISSUE;
                    end
                end

                ISSUE: begin
                    if (transfer && (InstrCount != 16'hFFFF)) begin
                        InstrCount <= InstrCount + 16'd1;
                    end
                    // A redirect coincident with a transfer still counts the
                    // accepted instruction, but the next PC is the target.
                    if (BranchTaken) begin
                        pc    <= BranchTarget;
                        state <= FETCH;
                    end else if (transfer) begin
                        pc    <= pc + PC_W'(1);
                        state <= FETCH;
                    end
                end

                HALT: begin
                    state <= HALT;
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only. The read enable is also
    // gated by rst_n so it stays low while reset is held even though the
    // state register already reads FETCH, and rises in the first cycle after
    // release without losing a cycle.
    assign imem_en    = rst_n && (state == FETCH);
    assign imem_addr  = pc;
    assign InstrValid = (state == ISSUE);
    assign Halted     = (state == HALT);
    // The decoder sees NOP whenever nothing is offered.
    assign opcode     = InstrValid ? ir[INSTR_W-1 -: 4] : 4'b0000;
    assign Operands   = ir[INSTR_W-5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch -- self-checking bench for instr_fetch
//
// A synchronous memory model answers reads. A reference model tracks the
// fetch unit as "which PC is being fetched, how many cycles since that fetch
// began, halted or not, how many accepted", and derives every expected output
// from that plus the memory contents. Directed sequences cover reset, the
// basic fetch cadence, stalls, redirects, PC wrap and HALT; a randomized
// phase then exercises arbitrary ready/redirect/reset mixes.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    logic               clk;
    logic               rst_n;
    logic               imem_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [3:0]         opcode;
    logic [INSTR_W-5:0] Operands;
    logic [PC_W-1:0]    PCOut;
    logic               InstrValid;
    logic               InstrReady;
    logic               BranchTaken;
    logic [PC_W-1:0]    BranchTarget;
    logic               Halted;
    logic [15:0]        InstrCount;

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .opcode       (opcode),
        .Operands     (Operands),
        .PCOut        (PCOut),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Halted       (Halted),
        .InstrCount   (InstrCount)
    );

    always #5 clk = ~clk;

    // Instruction memory: read data appears the cycle after the enable.
    logic [INSTR_W-1:0] mem [256];
    always @(posedge clk) begin
        if (imem_en) imem_data <= mem[imem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [7:0] m_pc;
    int         m_age;      // cycles since the current fetch began (0,1,>=2)
    bit         m_halted;
    int         m_count;

    task automatic model_edge();
        bit valid;
        logic [15:0] word;
        if (!rst_n) begin
            m_pc = 8'h00; m_age = 0; m_halted = 0; m_count = 0;
        end else if (!m_halted) begin
            valid = (m_age >= 2);
            word  = mem[m_pc];
            if (valid && InstrReady && m_count < 65535) m_count++;
            if (BranchTaken) begin
                m_pc = BranchTarget; m_age = 0;
            end else if (valid && InstrReady) begin
                m_pc = m_pc + 8'd1; m_age = 0;
            end else if (m_age == 1 && word[15:12] == 4'hF) begin
                m_halted = 1;
            end else if (m_age < 2) begin
                m_age++;
            end
        end
    endtask

    task automatic compare_all();
        bit exp_en, exp_valid;
        logic [15:0] word;
        exp_en    = rst_n && !m_halted && (m_age == 0);
        exp_valid = !m_halted && (m_age >= 2);
        word      = mem[m_pc];
        check("imem_en", 32'(imem_en), 32'(exp_en));
        if (exp_en) check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("InstrValid", 32'(InstrValid), 32'(exp_valid));
        check("Halted", 32'(Halted), 32'(m_halted));
        check("InstrCount", 32'(InstrCount), 32'(m_count));
        check("opcode", 32'(opcode), exp_valid ? 32'(word[15:12]) : 32'd0);
        if (exp_valid) begin
            check("Operands", 32'(Operands), 32'(word[11:0]));
            check("PCOut", 32'(PCOut), 32'(m_pc));
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare mid-cycle.
    task automatic step(input bit rdy, input bit br, input logic [7:0] tgt, input bit rst);
        InstrReady   = rdy;
        BranchTaken  = br;
        BranchTarget = tgt;
        rst_n        = rst;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    int halted_cycles;

    initial begin
        clk = 1'b0; rst_n = 1'b0; InstrReady = 1'b0; BranchTaken = 1'b0;
        BranchTarget = '0; imem_data = '0;
        m_pc = 8'h00; m_age = 0; m_halted = 0; m_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]     = 16'h1123;
        mem[1]     = 16'h2456;
        mem[2]     = 16'h3ABC;
        mem[3]     = 16'hF000;
        mem[8'h10] = 16'h5010;
        mem[8'h40] = 16'h6040;
        mem[8'h80] = 16'h8080;
        mem[8'hFF] = 16'h7123;

        // Reset held: every output at its reset value.
        step(1, 1, 8'h55, 0);
        step(1, 0, 8'h00, 0);
        check("rst Operands", 32'(Operands), 32'd0);
        check("rst PCOut", 32'(PCOut), 32'd0);
        check("rst opcode", 32'(opcode), 32'd0);
        check("rst imem_en", 32'(imem_en), 32'd0);
        check("rst imem_addr", 32'(imem_addr), 32'd0);

        // First cycle after release: read address 0.
        rst_n = 1'b1;
        #1;
        check("rel imem_en", 32'(imem_en), 32'd1);
        check("rel imem_addr", 32'(imem_addr), 32'd0);

        // Back-to-back issue with ready held high.
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        check("c2 valid", 32'(InstrValid), 32'd1);
        check("c2 opcode", 32'(opcode), 32'd1);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        check("c5 opcode", 32'(opcode), 32'd2);
        step(1, 0, 8'h00, 1);
        check("c5 count", 32'(InstrCount), 32'd2);

        // Stall in ISSUE: held instruction frozen, no fetch, PC frozen.
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h00, 1);
            check("stall opcode", 32'(opcode), 32'h3);
            check("stall Operands", 32'(Operands), 32'hABC);
            check("stall PCOut", 32'(PCOut), 32'h02);
            check("stall imem_en", 32'(imem_en), 32'd0);
            check("stall imem_addr", 32'(imem_addr), 32'h02);
        end

        // Redirect during WAIT: the word for address 3 (a HALT) is dropped.
        step(1, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'h40, 1);
        check("brw imem_en", 32'(imem_en), 32'd1);
        check("brw imem_addr", 32'(imem_addr), 32'h40);
        check("brw count", 32'(InstrCount), 32'd3);
        check("brw halted", 32'(Halted), 32'd0);

        // Redirect coincident with a transfer at PCOut 0x10.
        step(0, 1, 8'h10, 1);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        check("brx PCOut", 32'(PCOut), 32'h10);
        step(1, 1, 8'h80, 1);
        check("brx count", 32'(InstrCount), 32'd4);
        check("brx imem_addr", 32'(imem_addr), 32'h80);

        // PC wrap: transfer at 0xFF fetches 0x00 next.
        step(0, 1, 8'hFF, 1);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        check("wrap PCOut", 32'(PCOut), 32'hFF);
        step(1, 0, 8'h00, 1);
        check("wrap imem_addr", 32'(imem_addr), 32'h00);
        check("wrap imem_en", 32'(imem_en), 32'd1);

        // Run 0,1,2 then fetch the HALT word at address 3.
        repeat (11) step(1, 0, 8'h00, 1);
        check("halt Halted", 32'(Halted), 32'd1);
        check("halt valid", 32'(InstrValid), 32'd0);
        repeat (4) step(1, 1, 8'h40, 1);
        check("halt hold", 32'(Halted), 32'd1);
        check("halt imem_en", 32'(imem_en), 32'd0);
        step(1, 1, 8'h40, 0);
        check("halt rst", 32'(Halted), 32'd0);
        check("halt rst count", 32'(InstrCount), 32'd0);
        rst_n = 1'b1;
        #1;
        check("halt refetch en", 32'(imem_en), 32'd1);
        check("halt refetch addr", 32'(imem_addr), 32'd0);

        // Randomized phase: fresh memory, rare HALT words.
        for (int i = 0; i < 256; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w[15:12] == 4'hF && ($urandom % 4) != 0) w[15:12] = 4'($urandom_range(0, 14));
            mem[i] = w;
        end
        halted_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            bit rst;
            halted_cycles = m_halted ? halted_cycles + 1 : 0;
            rst = !(($urandom % 300) == 0 || halted_cycles > 6);
            step(($urandom % 3) != 0, ($urandom % 10) == 0, 8'($urandom), rst);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
